// File: rtl/tetris_soc_pio_pkg.sv
// tetris_soc_pio_pkg: register addresses and pulse-unit state shared by the SoC PIO blocks
package tetris_soc_pio_pkg;
    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_PULSE     = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    typedef enum logic {PULSE_IDLE, PULSE_ACTIVE} pulse_state_t;
endpackage

// File: rtl/tetris_soc_pio_pulse_timer.sv
// tetris_soc_pio_pulse_timer: holds a bit mask high for len cycles, retriggerable
module tetris_soc_pio_pulse_timer
    import tetris_soc_pio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [WIDTH-1:0] mask_in,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] mask_out,
    output logic             busy
);
    pulse_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mask;
    logic             w_fire;
    assign w_fire   = trigger && (len != '0) && (mask_in != '0);
    assign mask_out = r_mask;
    assign busy     = (r_state == PULSE_ACTIVE);
    // A trigger takes priority over the expiry decrement, so a retrigger on the last cycle extends the pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PULSE_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else if (w_fire) begin
            r_state <= PULSE_ACTIVE;
            r_cnt   <= len;
            r_mask  <= r_mask | mask_in;
        end else if (r_state == PULSE_ACTIVE) begin
            if (r_cnt == CNT_W'(1)) begin
                r_state <= PULSE_IDLE;
                r_cnt   <= '0;
                r_mask  <= '0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/tetris_soc_led_pio.sv
// tetris_soc_led_pio: Avalon-MM output PIO with atomic set/clear and a self-timed pulse mask
module tetris_soc_led_pio
    import tetris_soc_pio_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_len;
    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_mask;
    logic             w_busy;
    logic [31:0]      w_rdata;
    logic             w_unused;
    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;
    assign out_port = r_data | w_mask;
    tetris_soc_pio_pulse_timer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pulse (
        .clk      (clk),
        .reset    (reset),
        .trigger  (w_wr && address == ADDR_PULSE),
        .mask_in  (w_wd),
        .len      (r_len),
        .mask_out (w_mask),
        .busy     (w_busy)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VAL;
            r_len  <= '0;
        end else if (w_wr) begin
            if (address == ADDR_DATA)      r_data <= w_wd;
            if (address == ADDR_OUTSET)    r_data <= r_data | w_wd;
            if (address == ADDR_OUTCLEAR)  r_data <= r_data & ~w_wd;
            if (address == ADDR_PULSE_LEN) r_len  <= writedata[CNT_W-1:0];
        end
    end
    always_comb begin
        w_rdata = address == ADDR_DATA      ? 32'(r_data) :
                  address == ADDR_PULSE_LEN ? 32'(r_len)  :
                  address == ADDR_PULSE     ? 32'(w_mask) :
                  address == ADDR_STATUS    ? 32'(w_busy) : '0;
    end
    always_ff @(posedge clk) begin
        readdata <= reset ? '0 : w_rdata;
    end
endmodule

// File: tb/tb_tetris_soc_led_pio.sv
// tb_tetris_soc_led_pio: directed-vector bench for the LED output PIO
module tb_tetris_soc_led_pio;
    logic        clk = 0;
    logic        reset = 1;
    logic [2:0]  address = '0;
    logic        chipselect = 0;
    logic        write_n = 1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [31:0] rd_val;
    int          n_chk = 0;
    int          n_fail = 0;

    tetris_soc_led_pio #(.WIDTH(8), .CNT_W(24), .RESET_VAL(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge and the task returns at the following negedge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        @(negedge clk);
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1; write_n = 1;
        @(negedge clk);
        d = readdata;
        chipselect = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_rd", readdata, 32'h0);
        reset = 0;
        // 1: DATA write and read-back
        wr(3'd0, 32'hFFFF_FFA5);
        chk("data_out", 32'(out_port), 32'hA5);
        rd(3'd0, rd_val);
        chk("data_rd", rd_val, 32'h0000_00A5);
        // 2: set/clear, reserved address, PULSE_LEN width
        wr(3'd0, 32'hF0);
        wr(3'd4, 32'h0F);
        chk("outset", 32'(out_port), 32'hFF);
        wr(3'd5, 32'h81);
        chk("outclr", 32'(out_port), 32'h7E);
        wr(3'd6, 32'hFF);
        chk("rsvd_wr", 32'(out_port), 32'h7E);
        rd(3'd6, rd_val);
        chk("rsvd_rd", rd_val, 32'h0);
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, rd_val);
        chk("len_rd", rd_val, 32'h00FF_FFFF);
        // 3: single pulse of 3 cycles
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h0);
        wr(3'd2, 32'h01);
        address = 3'd3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p3_out%0d", i), 32'(out_port), (i < 3) ? 32'h01 : 32'h00);
            @(negedge clk);
            chk($sformatf("p3_st%0d", i), readdata, (i < 3) ? 32'h1 : 32'h0);
        end
        // 4: retrigger merges masks and restarts the count
        wr(3'd1, 32'd4);
        wr(3'd2, 32'h01);
        chk("p4_a", 32'(out_port), 32'h01);
        @(negedge clk);
        chk("p4_b", 32'(out_port), 32'h01);
        wr(3'd2, 32'h02);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p4_out%0d", i), 32'(out_port), (i < 4) ? 32'h03 : 32'h00);
            @(negedge clk);
        end
        rd(3'd2, rd_val);
        chk("p4_mask", rd_val, 32'h0);
        // 5: zero length ignores the pulse write
        wr(3'd0, 32'h10);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'hFF);
        chk("p5_out", 32'(out_port), 32'h10);
        rd(3'd3, rd_val);
        chk("p5_st", rd_val, 32'h0);
        // 6: reset during an active pulse beats a same-cycle DATA write
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h3C);
        wr(3'd2, 32'h40);
        chk("p6_pre", 32'(out_port), 32'h7C);
        reset = 1; address = 3'd0; writedata = 32'h11; chipselect = 1; write_n = 0;
        @(negedge clk);
        reset = 0; chipselect = 0; write_n = 1;
        chk("p6_out", 32'(out_port), 32'h00);
        chk("p6_rd", readdata, 32'h0);
        rd(3'd3, rd_val);
        chk("p6_st", rd_val, 32'h0);
        rd(3'd1, rd_val);
        chk("p6_len", rd_val, 32'h0);
        repeat (5) @(negedge clk);
        chk("p6_hold", 32'(out_port), 32'h00);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
